// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file writeback arbiter with load scoreboard
// Round-robin grant between ALU and load-return writebacks, registered write port, RAW hazard flag.
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        load_issue,
  input  logic [4:0]  load_issue_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        hazard,
  output logic        write,
  output logic [4:0]  rd,
  output logic [31:0] reg_write,
  output logic [31:0] pending
);

  logic        prio_q, prio_d;
  logic        write_q, write_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;
  logic [31:0] pending_q, pending_d;

  // prio_q: 0 favours MEM, 1 favours ALU; a lone requester wins regardless
  always_comb begin
    alu_ready = rst & alu_valid & (~mem_valid | prio_q);
    mem_ready = rst & mem_valid & (~alu_valid | ~prio_q);
  end

  always_comb begin
    prio_d  = prio_q;
    write_d = 1'b0;
    rd_d    = rd_q;
    data_d  = data_q;
    if (alu_ready) begin
      prio_d  = 1'b0;
      write_d = (alu_rd != 5'd0);
      rd_d    = alu_rd;
      data_d  = alu_data;
    end else if (mem_ready) begin
      prio_d  = 1'b1;
      write_d = (mem_rd != 5'd0);
      rd_d    = mem_rd;
      data_d  = mem_data;
    end
  end

  // Set is applied after clear so a newer load to the same register stays pending
  always_comb begin
    pending_d = pending_q;
    if (mem_ready) begin
      pending_d[mem_rd] = 1'b0;
    end
    if (load_issue && (load_issue_rd != 5'd0)) begin
      pending_d[load_issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prio_q    <= 1'b0;
      write_q   <= 1'b0;
      rd_q      <= 5'd0;
      data_q    <= 32'd0;
      pending_q <= 32'd0;
    end else begin
      prio_q    <= prio_d;
      write_q   <= write_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      pending_q <= pending_d;
    end
  end

  // The output-stage write lands at the next edge, so its register is not yet readable
  always_comb begin
    hazard = pending_q[rs1] | pending_q[rs2] |
             (write_q & (((rd_q == rs1) & (rs1 != 5'd0)) |
                         ((rd_q == rs2) & (rs2 != 5'd0))));
  end

  assign write     = write_q;
  assign rd        = rd_q;
  assign reg_write = data_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, load_issue;
  logic [4:0]  alu_rd, mem_rd, load_issue_rd, rs1, rs2;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, hazard, write;
  logic [4:0]  rd;
  logic [31:0] reg_write, pending;

  typedef struct packed {
    logic        write;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t         exp_q[$];
  logic [4:0]  last_rd;
  logic [31:0] last_data;
  int          n_cmp = 0;
  int          n_err = 0;

  localparam int G_NONE = 0;
  localparam int G_ALU  = 1;
  localparam int G_MEM  = 2;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .load_issue(load_issue), .load_issue_rd(load_issue_rd),
    .rs1(rs1), .rs2(rs2), .hazard(hazard),
    .write(write), .rd(rd), .reg_write(reg_write), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: retire last cycle's expected writeback, check grant, predict next writeback.
  task automatic step(input int exp_g);
    wb_t e, n;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("write", {31'd0, write}, {31'd0, e.write});
      check("rd", {27'd0, rd}, {27'd0, e.rd});
      check("reg_write", reg_write, e.data);
    end
    check("alu_ready", {31'd0, alu_ready}, (exp_g == G_ALU) ? 32'd1 : 32'd0);
    check("mem_ready", {31'd0, mem_ready}, (exp_g == G_MEM) ? 32'd1 : 32'd0);
    n.write = 1'b0;
    n.rd    = last_rd;
    n.data  = last_data;
    if (!rst) begin
      n.rd   = 5'd0;
      n.data = 32'd0;
    end else if (exp_g == G_ALU) begin
      n.write = (alu_rd != 5'd0);
      n.rd    = alu_rd;
      n.data  = alu_data;
    end else if (exp_g == G_MEM) begin
      n.write = (mem_rd != 5'd0);
      n.rd    = mem_rd;
      n.data  = mem_data;
    end
    last_rd   = n.rd;
    last_data = n.data;
    exp_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'hB;
    load_issue = 1'b0; load_issue_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    last_rd = 5'd0; last_data = 32'd0;
    @(posedge clk); #1;

    step(G_NONE);
    step(G_NONE);
    check("pending_reset", pending, 32'd0);

    rst = 1'b1;
    for (int i = 0; i < 4; i++) step((i % 2 == 0) ? G_MEM : G_ALU);

    mem_valid = 1'b0; alu_rd = 5'd7; alu_data = 32'h1234;
    step(G_ALU);

    alu_rd = 5'd0; alu_data = 32'h55; mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'h66;
    step(G_MEM);
    mem_valid = 1'b0;
    step(G_ALU);

    alu_valid = 1'b0; rs1 = 5'd5;
    #1 check("hazard_pre", {31'd0, hazard}, 32'd0);
    load_issue = 1'b1; load_issue_rd = 5'd5;
    step(G_NONE);
    check("pending_set5", pending, 32'h0000_0020);
    check("hazard_pend5", {31'd0, hazard}, 32'd1);

    load_issue = 1'b0; mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'h77;
    step(G_MEM);
    check("pending_clr5", pending, 32'd0);
    check("hazard_wb5", {31'd0, hazard}, 32'd1);
    mem_valid = 1'b0;
    step(G_NONE);
    check("hazard_done5", {31'd0, hazard}, 32'd0);

    rs1 = 5'd0; rs2 = 5'd9;
    load_issue = 1'b1; load_issue_rd = 5'd9;
    step(G_NONE);
    check("pending_set9", pending, 32'h0000_0200);
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
    step(G_MEM);
    check("pending_setclr9", pending, 32'h0000_0200);
    check("hazard_rs2", {31'd0, hazard}, 32'd1);
    load_issue = 1'b0;
    step(G_MEM);
    check("pending_clr9", pending, 32'd0);

    mem_valid = 1'b0; load_issue = 1'b1; load_issue_rd = 5'd12;
    step(G_NONE);
    check("pending_set12", pending, 32'h0000_1000);
    load_issue = 1'b0; rst = 1'b0; alu_valid = 1'b1; mem_valid = 1'b1;
    step(G_NONE);
    check("pending_midrst", pending, 32'd0);
    rst = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
    step(G_NONE);
    step(G_NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
